matrix_op_sequencer: RTL and testbench
======================================

// Module: matrix_op_sequencer
// PURPOSE
//   Upstream controller for the 3x3 matrix ALU. Takes one op command plus a stream of operand words.
//   Drives the ALU sel/eleIn bus to load c/E/F, pulses the op code for exactly one cycle,
//   then streams results (9 G words or 1 det word) out over valid/ready.
//   Sits between the host word FIFO and the ALU; one operation in flight at a time.
// PARAMETERS
//   DW           32    data word width (ALU element width)
//   SELW         6     ALU select width
//   TIMEOUT_CYC  1024  max idle cycles waiting on in_valid (TIMEOUT_EN only)
// PORTS
//   clk          in   1     clock
//   reset        in   1     asynchronous, active-high reset
//   cmd_valid    in   1     command present
//   cmd_ready    out  1     command accepted (high only in IDLE)
//   cmd_op       in   3     0 trans,1 add,2 sub,3 mul,4 scale,5 det; 6-7 illegal
//   in_valid     in   1     operand word present
//   in_ready     out  1     operand word accepted
//   in_data      in   DW    operand word, row-major order
//   out_valid    out  1     result word present
//   out_ready    in   1     result word taken
//   out_data     out  DW    result word (= alu_ele_out)
//   out_last     out  1     final result word of operation
//   alu_sel      out  SELW  ALU select
//   alu_ele_in   out  DW    ALU element input (= in_data)
//   alu_ele_out  in   DW    ALU element output
//   busy         out  1     state != IDLE
//   err          out  1     1-cycle pulse: illegal op or timeout
// BEHAVIOUR
//   Reset (async): state=IDLE, idx=0, op=0, busy=0, out_valid=0, out_last=0, err=0, alu_sel=27.
//   States: IDLE -> [LOAD_C] -> LOAD_E -> [LOAD_F] -> EXEC -> READ -> IDLE.
//   IDLE: cmd_ready=1; on cmd_valid latch op, idx=0.
//     op 4 -> LOAD_C; op 0-5 otherwise -> LOAD_E; op 6/7 -> err pulse, stay IDLE.
//   LOAD_C: in_ready=1; beat drives alu_sel=40 -> LOAD_E.
//   LOAD_E: in_ready=1; each beat drives alu_sel=idx (0-8).
//     Beat at idx 8 -> LOAD_F (ops 1,2,3) else EXEC.
//   LOAD_F: in_ready=1; each beat drives alu_sel=9+idx; beat at idx 8 -> EXEC.
//   Load rule: alu_sel carries a load index ONLY in a cycle with in_valid&&in_ready; otherwise 27.
//     No-beat cycles therefore leave ALU operand latches unchanged.
//   EXEC: exactly one cycle, alu_sel = 28+op; ALU G/det register updates at its end -> READ, idx=0.
//   READ: out_valid=1, out_data=alu_ele_out.
//     Ops 0-4: alu_sel=18+idx; advance on out_ready; out_last at idx 8.
//     Op 5: alu_sel=27, one word, out_last=1.
//     out_data/out_last held stable while out_valid&&!out_ready.
//     Final handshake -> IDLE same edge.
//   Latency: last operand beat -> first out_valid = 2 cycles (EXEC, then READ).
//   alu_sel, alu_ele_in, in_ready, out_valid, out_last are combinational from state/idx/handshake.
//   Counter idx 0..8 resets to 0 on every state change; never wraps beyond 8.
//   cmd_valid outside IDLE ignored; in_valid outside LOAD_* ignored (in_ready=0).
//   Reset mid-operation: immediate return to IDLE; partial ALU operand contents are don't-care.
// CONFIGURATION
//   TIMEOUT_EN defined:
//     In LOAD_*, a counter tracks consecutive cycles with in_valid=0.
//     Reaching TIMEOUT_CYC -> err pulse, state=IDLE, no EXEC issued.
//   TIMEOUT_EN undefined: no counter; LOAD_* waits forever; err only from illegal op.
// STRUCTURE
//   matrix_pkg: op encodings (OP_TRANS..OP_DET), sel constants
//     SEL_E_BASE=0, SEL_F_BASE=9, SEL_G_BASE=18, SEL_DET=27, SEL_OP_BASE=28, SEL_C=40;
//     state enum; N_ELEM=9.
//   Sub-module mat_idx_counter: 0..N_ELEM-1 counter with inc, clr, is_last outputs.
// TESTING
//   add:
//     E=1..9, F=10..18 -> alu_sel 0..17 on beats, one cycle 29;
//     out 11,13,...,27; out_last on 9th only.
//   det:
//     E=diag(2,3,4) -> one cycle sel 33; single out_data=24, out_last=1;
//     no LOAD_F beats accepted.
//   scale:
//     c=3 then E=1..9 -> sel 40 first, EXEC sel 32; out 3,6,...,27.
//   stalls:
//     in_valid gaps during LOAD_E show alu_sel=27.
//     out_ready low 3 cycles at word 4 -> out_data held, no word skipped or duplicated.
//   illegal/reset:
//     cmd_op=7 -> err pulse, busy stays 0.
//     reset asserted after 5 E beats -> IDLE next; clean add afterwards correct.
//   TIMEOUT_EN with TIMEOUT_CYC=16:
//     stop in_valid mid-LOAD_F -> err at cycle 16, IDLE, sel 28-33 never seen.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared encodings for the 3x3 matrix ALU sequencer: op codes, ALU select map,
// sequencer state enum and element count.
package matrix_pkg;

    localparam int N_ELEM = 9;
    localparam int IDXW   = 4;

    localparam logic [2:0] OP_TRANS = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_SCALE = 3'd4;
    localparam logic [2:0] OP_DET   = 3'd5;

    localparam int SEL_E_BASE  = 0;
    localparam int SEL_F_BASE  = 9;
    localparam int SEL_G_BASE  = 18;
    localparam int SEL_DET     = 27;
    localparam int SEL_OP_BASE = 28;
    localparam int SEL_C       = 40;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_C = 3'd1,
        ST_LOAD_E = 3'd2,
        ST_LOAD_F = 3'd3,
        ST_EXEC   = 3'd4,
        ST_READ   = 3'd5
    } state_t;

endpackage

// File: rtl/mat_idx_counter.sv
// Element index counter 0..N_ELEM-1; saturates at the last element, clr has priority.
module mat_idx_counter
    import matrix_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    output logic [IDXW-1:0] idx,
    output logic            is_last
);

    assign is_last = (idx == IDXW'(N_ELEM - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc && !is_last) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Sequences one matrix ALU operation: loads c/E/F, issues the op for one cycle, streams results.
// Optional TIMEOUT_EN aborts a load that sees TIMEOUT_CYC consecutive cycles without in_valid.
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter int DW   = 32,
    parameter int SELW = 6
`ifdef TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic [SELW-1:0] alu_sel,
    output logic [DW-1:0]   alu_ele_in,
    input  logic [DW-1:0]   alu_ele_out,
    output logic            busy,
    output logic            err,
    output state_t          state_dbg
);

    // All three ports use valid/ready: a word moves on a rising edge where both
    // are high; the producer holds data stable while valid && !ready.

    state_t           state, state_next;
    logic [2:0]       op_q;
    logic [IDXW-1:0]  idx;
    logic             is_last;
    logic             idx_inc;
    logic             err_c;
    logic             timeout;
    logic             needs_f;

    assign needs_f    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);
    assign busy       = (state != ST_IDLE);
    assign out_data   = alu_ele_out;
    assign alu_ele_in = in_data;
    assign state_dbg  = state;

    mat_idx_counter u_idx (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_next != state),
        .inc     (idx_inc),
        .idx     (idx),
        .is_last (is_last)
    );

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] idle_cnt;
    logic          in_load;

    assign in_load = (state == ST_LOAD_C) || (state == ST_LOAD_E) || (state == ST_LOAD_F);
    assign timeout = in_load && !in_valid && (idle_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (!in_load || in_valid || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            op_q  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            err   <= err_c;
            if (state == ST_IDLE && cmd_valid) begin
                op_q <= cmd_op;
            end
        end
    end

    // alu_sel carries a load index only on an accepted beat, so stalls leave ALU latches intact.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        alu_sel    = SELW'(SEL_DET);
        idx_inc    = 1'b0;
        err_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_op > OP_DET)          err_c      = 1'b1;
                    else if (cmd_op == OP_SCALE)  state_next = ST_LOAD_C;
                    else                          state_next = ST_LOAD_E;
                end
            end
            ST_LOAD_C: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    alu_sel    = SELW'(SEL_C);
                    state_next = ST_LOAD_E;
                end
            end
            ST_LOAD_E: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    alu_sel = SELW'(SEL_E_BASE + int'(idx));
                    idx_inc = 1'b1;
                    if (is_last) state_next = needs_f ? ST_LOAD_F : ST_EXEC;
                end
            end
            ST_LOAD_F: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    alu_sel = SELW'(SEL_F_BASE + int'(idx));
                    idx_inc = 1'b1;
                    if (is_last) state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_sel    = SELW'(SEL_OP_BASE + int'(op_q));
                state_next = ST_READ;
            end
            ST_READ: begin
                out_valid = 1'b1;
                if (op_q == OP_DET) begin
                    out_last = 1'b1;
                    if (out_ready) state_next = ST_IDLE;
                end else begin
                    alu_sel  = SELW'(SEL_G_BASE + int'(idx));
                    out_last = is_last;
                    idx_inc  = out_ready;
                    if (out_ready && is_last) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (timeout) begin
            state_next = ST_IDLE;
            err_c      = 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Bench for matrix_op_sequencer: table of whole operations against a small ALU model,
// plus directed sequences for reset mid-load, illegal op and (with TIMEOUT_EN) load timeout.
module tb_matrix_op_sequencer;
    import matrix_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic [5:0]  alu_sel;
    logic [31:0] alu_ele_in, alu_ele_out;
    logic        busy, err;
    state_t      state_dbg;

    int checks = 0;
    int failures = 0;
    int exec_seen = 0;

    always #5 clk = ~clk;

    matrix_op_sequencer #(
        .DW(32), .SELW(6)
`ifdef TIMEOUT_EN
        , .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .alu_sel(alu_sel), .alu_ele_in(alu_ele_in), .alu_ele_out(alu_ele_out),
        .busy(busy), .err(err), .state_dbg(state_dbg)
    );

    // ALU model driven purely by alu_sel
    logic [31:0] e_m[9], f_m[9], g_m[9];
    logic [31:0] c_m, det_m;

    function automatic logic [31:0] alu_g(input int op, input int i);
        int r, c;
        logic [31:0] acc;
        r = i / 3;
        c = i % 3;
        acc = 0;
        case (op)
            0: acc = e_m[c*3+r];
            1: acc = e_m[i] + f_m[i];
            2: acc = e_m[i] - f_m[i];
            3: for (int k = 0; k < 3; k++) acc = acc + e_m[r*3+k] * f_m[k*3+c];
            default: acc = c_m * e_m[i];
        endcase
        return acc;
    endfunction

    function automatic logic [31:0] det3();
        return e_m[0] * (e_m[4] * e_m[8] - e_m[5] * e_m[7])
             - e_m[1] * (e_m[3] * e_m[8] - e_m[5] * e_m[6])
             + e_m[2] * (e_m[3] * e_m[7] - e_m[4] * e_m[6]);
    endfunction

    always @(posedge clk) begin
        int s;
        s = int'(alu_sel);
        if (s < 9) e_m[s] <= alu_ele_in;
        else if (s < 18) f_m[s-9] <= alu_ele_in;
        else if (s == 40) c_m <= alu_ele_in;
        else if (s >= 28 && s <= 32) begin
            for (int i = 0; i < 9; i++) g_m[i] <= alu_g(s - 28, i);
        end else if (s == 33) det_m <= det3();
        if (s >= 28 && s <= 33) exec_seen <= exec_seen + 1;
    end

    always_comb begin
        alu_ele_out = det_m;
        if (alu_sel >= 6'd18 && alu_sel <= 6'd26) alu_ele_out = g_m[int'(alu_sel) - 18];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        bit          has_c;
        bit          has_f;
        logic [31:0] c;
        logic [31:0] e[9];
        logic [31:0] f[9];
        logic [31:0] exp[9];
        int          n_out;
        int          stall_word;
        bit          gaps;
    } op_vec_t;

    op_vec_t vecs[7];

    task automatic beat(input logic [31:0] data, input int exp_sel, input bit gap, input string name);
        if (gap) begin
            @(negedge clk);
            cmd_valid = 1'b0; in_valid = 1'b0; in_data = 32'hbad0_0bad;
            #1;
            chk({name, "_gap_sel"}, alu_sel, 27);
            chk({name, "_gap_rdy"}, in_ready, 1);
        end
        @(negedge clk);
        cmd_valid = 1'b0; in_valid = 1'b1; in_data = data;
        #1;
        chk({name, "_rdy"}, in_ready, 1);
        chk({name, "_sel"}, alu_sel, exp_sel);
    endtask

    task automatic run_vec(input op_vec_t v);
        int ex0;
        ex0 = exec_seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = v.op; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        if (v.has_c) beat(v.c, 40, 1'b0, "c_beat");
        for (int i = 0; i < 9; i++) beat(v.e[i], i, v.gaps && (i % 2 == 1), "e_beat");
        if (v.has_f) for (int i = 0; i < 9; i++) beat(v.f[i], 9 + i, 1'b0, "f_beat");
        // EXEC: junk command and operand must be ignored
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hdead_beef; cmd_valid = 1'b1; cmd_op = OP_ADD;
        #1;
        chk("exec_sel", alu_sel, 28 + int'(v.op));
        chk("exec_in_ready", in_ready, 0);
        chk("exec_cmd_ready", cmd_ready, 0);
        chk("exec_out_valid", out_valid, 0);
        for (int i = 0; i < v.n_out; i++) begin
            for (int s = 0; s < ((i == v.stall_word) ? 3 : 0); s++) begin
                @(negedge clk);
                in_valid = 1'b0; cmd_valid = 1'b0; out_ready = 1'b0;
                #1;
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, v.exp[i]);
                chk("stall_last", out_last, (i == v.n_out - 1) ? 1 : 0);
            end
            @(negedge clk);
            in_valid = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
            #1;
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, v.exp[i]);
            chk("out_last", out_last, (i == v.n_out - 1) ? 1 : 0);
            chk("read_sel", alu_sel, (v.op == OP_DET) ? 27 : 18 + i);
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("done_busy", busy, 0);
        chk("done_out_valid", out_valid, 0);
        chk("done_state", state_dbg, ST_IDLE);
        chk("exec_once", exec_seen - ex0, 1);
    endtask

    initial begin
        // operation table: 0 add, 1 det, 2 scale, 3 add with stalls, 4 trans, 5 sub, 6 mul
        for (int k = 0; k < 7; k++) begin
            vecs[k].has_c = 1'b0; vecs[k].has_f = 1'b0; vecs[k].c = 0;
            vecs[k].n_out = 9; vecs[k].stall_word = -1; vecs[k].gaps = 1'b0;
            for (int i = 0; i < 9; i++) begin
                vecs[k].e[i] = i + 1; vecs[k].f[i] = i + 10; vecs[k].exp[i] = 0;
            end
        end
        vecs[0].op = OP_ADD; vecs[0].has_f = 1'b1;
        for (int i = 0; i < 9; i++) vecs[0].exp[i] = 2 * i + 11;
        vecs[1].op = OP_DET; vecs[1].n_out = 1; vecs[1].exp[0] = 24;
        for (int i = 0; i < 9; i++) vecs[1].e[i] = 0;
        vecs[1].e[0] = 2; vecs[1].e[4] = 3; vecs[1].e[8] = 4;
        vecs[2].op = OP_SCALE; vecs[2].has_c = 1'b1; vecs[2].c = 3;
        for (int i = 0; i < 9; i++) vecs[2].exp[i] = 3 * (i + 1);
        vecs[3] = vecs[0]; vecs[3].gaps = 1'b1; vecs[3].stall_word = 3;
        vecs[4].op = OP_TRANS;
        vecs[4].exp = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
        vecs[5].op = OP_SUB; vecs[5].has_f = 1'b1;
        for (int i = 0; i < 9; i++) begin
            vecs[5].e[i] = i + 10; vecs[5].f[i] = i + 1; vecs[5].exp[i] = 9;
        end
        vecs[6].op = OP_MUL; vecs[6].has_f = 1'b1;
        vecs[6].f = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        for (int i = 0; i < 9; i++) vecs[6].exp[i] = i + 1;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; in_valid = 1'b0;
        in_data = 32'd0; out_ready = 1'b0;
        #1;
        chk("rst_state", state_dbg, ST_IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err", err, 0);
        chk("rst_sel", alu_sel, 27);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // reset after 5 E beats, then a clean add
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ADD;
        for (int i = 0; i < 5; i++) beat(32'd100 + i, i, 1'b0, "prerst_beat");
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        #1;
        chk("midrst_state", state_dbg, ST_IDLE);
        chk("midrst_busy", busy, 0);
        chk("midrst_sel", alu_sel, 27);
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[0]);

        // illegal op
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd7;
        #1;
        chk("ill_cmd_ready", cmd_ready, 1);
        chk("ill_err_before", err, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("ill_err_pulse", err, 1);
        chk("ill_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("ill_err_clear", err, 0);
        chk("ill_busy2", busy, 0);

`ifdef TIMEOUT_EN
        begin
            int ex0, got;
            ex0 = exec_seen;
            got = 0;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = OP_ADD;
            for (int i = 0; i < 9; i++) beat(i + 1, i, 1'b0, "to_e_beat");
            for (int i = 0; i < 3; i++) beat(i + 10, 9 + i, 1'b0, "to_f_beat");
            for (int j = 1; j <= 40 && got == 0; j++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                if (err) got = j;
            end
            chk("to_idle_cycles", got - 1, 16);
            chk("to_busy", busy, 0);
            chk("to_no_exec", exec_seen - ex0, 0);
            @(negedge clk);
            #1;
            chk("to_err_clear", err, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
